fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the core. Keeps up to MaxOutstanding in-order

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_buf.sv | 75 +++++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-path types: address/instruction widths and the buffered fetch entry.
package core_pkg;

  localparam int unsigned Xlen = 32;
  localparam int unsigned Ilen = 32;

  localparam logic [Xlen-1:0] ResetPcDefault = '0;

  // One fetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic [Ilen-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Circular buffer of fetch entries with flush; head is readable combinationally.
module fetch_buf
  import core_pkg::*;
#(
  parameter int unsigned DepthLog2 = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  fetch_entry_t         push_entry_i,
  input  logic                 pop_i,
  output fetch_entry_t         head_o,
  output logic [DepthLog2:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned Depth = 2 ** DepthLog2;
  localparam logic [DepthLog2:0]   CountFull = (DepthLog2 + 1)'(Depth);
  localparam logic [DepthLog2:0]   CountOne  = (DepthLog2 + 1)'(1);
  localparam logic [DepthLog2-1:0] PtrOne    = DepthLog2'(1);

  fetch_entry_t         mem_q [Depth];
  logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DepthLog2:0]   count_q, count_d;
  logic                 do_push, do_pop;

  // Pointer/count update; a flush empties the buffer and wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CountFull) || do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: in-order request credits, stale-response dropping on
// redirect, and a small buffer of {pc, inst} toward the core.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned     DepthLog2      = 2,
  parameter int unsigned     MaxOutstanding = 2,
  parameter logic [Xlen-1:0] ResetPc        = ResetPcDefault
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [Xlen-1:0] redirect_pc_i,
  input  logic            hold_i,
  input  logic            instmem_ready_i,
  output logic            instmem_valid_o,
  output logic [Xlen-1:0] instmem_addr_o,
  input  logic [Ilen-1:0] instmem_rdata_i,
  input  logic            instmem_rvalid_i,
  output logic            inst_valid_o,
  output logic [Xlen-1:0] inst_pc_o,
  output logic [Ilen-1:0] inst_data_o,
  input  logic            inst_ready_i
);

  localparam int unsigned Depth = 2 ** DepthLog2;
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned TagW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned ResvW = DepthLog2 + 2;

  localparam logic [OutW-1:0]  OutMax    = OutW'(MaxOutstanding);
  localparam logic [OutW-1:0]  OutOne    = OutW'(1);
  localparam logic [TagW-1:0]  TagLast   = TagW'(MaxOutstanding - 1);
  localparam logic [TagW-1:0]  TagOne    = TagW'(1);
  localparam logic [ResvW-1:0] ResvLimit = ResvW'(Depth);
  localparam logic [Xlen-1:0]  PcStep    = Xlen'(4);

  logic [Xlen-1:0]    pc_q, pc_d;
  logic [OutW-1:0]    outstanding_q, outstanding_d;
  logic [OutW-1:0]    drop_q, drop_d;
  logic [TagW-1:0]    tag_wr_ptr_q, tag_wr_ptr_d;
  logic [TagW-1:0]    tag_rd_ptr_q, tag_rd_ptr_d;
  logic [Xlen-1:0]    tag_q [MaxOutstanding];

  logic               issue;
  logic [ResvW-1:0]   reserved;
  logic               buf_push, buf_pop, buf_full, buf_empty;
  logic [DepthLog2:0] buf_count;
  fetch_entry_t       buf_push_entry, buf_head;

  // Request side: issue only while a credit and a guaranteed buffer slot are free.
  // Slots held for live (non-dropped) requests count as occupied, so responses never overflow.
  always_comb begin
    reserved        = ResvW'(buf_count) + ResvW'(outstanding_q) - ResvW'(drop_q);
    instmem_valid_o = rst_ni && !hold_i && (outstanding_q < OutMax) && (reserved < ResvLimit);
    instmem_addr_o  = redirect_valid_i ? redirect_pc_i : pc_q;
    issue           = instmem_valid_o && instmem_ready_i;

    pc_d = pc_q;
    if (issue)                 pc_d = instmem_addr_o + PcStep;
    else if (redirect_valid_i) pc_d = redirect_pc_i;

    tag_wr_ptr_d = tag_wr_ptr_q;
    if (issue) tag_wr_ptr_d = (tag_wr_ptr_q == TagLast) ? '0 : tag_wr_ptr_q + TagOne;
  end

  // Response side: every response retires a tag; stale ones are discarded via the drop count.
  // The response arriving in a redirect cycle is always stale.
  always_comb begin
    tag_rd_ptr_d = tag_rd_ptr_q;
    if (instmem_rvalid_i) tag_rd_ptr_d = (tag_rd_ptr_q == TagLast) ? '0 : tag_rd_ptr_q + TagOne;

    outstanding_d = outstanding_q;
    case ({issue, instmem_rvalid_i})
      2'b10:   outstanding_d = outstanding_q + OutOne;
      2'b01:   outstanding_d = outstanding_q - OutOne;
      default: outstanding_d = outstanding_q;
    endcase

    drop_d = drop_q;
    if (redirect_valid_i)                      drop_d = outstanding_q - (instmem_rvalid_i ? OutOne : '0);
    else if (instmem_rvalid_i && drop_q != '0) drop_d = drop_q - OutOne;

    buf_push            = instmem_rvalid_i && !redirect_valid_i && (drop_q == '0);
    buf_push_entry.pc   = tag_q[tag_rd_ptr_q];
    buf_push_entry.inst = instmem_rdata_i;
    buf_pop             = inst_ready_i && inst_valid_o && !redirect_valid_i;
  end

  // Fetch PC, credit, drop and tag-pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= ResetPc;
      outstanding_q <= '0;
      drop_q        <= '0;
      tag_wr_ptr_q  <= '0;
      tag_rd_ptr_q  <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      tag_wr_ptr_q  <= tag_wr_ptr_d;
      tag_rd_ptr_q  <= tag_rd_ptr_d;
    end
  end

  for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_tag
    // Each tag slot remembers the address of the request issued into it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                    tag_q[gi] <= '0;
      else if (issue && tag_wr_ptr_q == TagW'(gi))    tag_q[gi] <= instmem_addr_o;
    end
  end

  fetch_buf #(
    .DepthLog2 (DepthLog2)
  ) u_fetch_buf (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (redirect_valid_i),
    .push_i       (buf_push),
    .push_entry_i (buf_push_entry),
    .pop_i        (buf_pop),
    .head_o       (buf_head),
    .count_o      (buf_count),
    .full_o       (buf_full),
    .empty_o      (buf_empty)
  );

  assign inst_valid_o = !buf_empty;
  assign inst_pc_o    = inst_valid_o ? buf_head.pc : '0;
  assign inst_data_o  = inst_valid_o ? buf_head.inst : '0;

  // A response is only legal while a request is in flight.
  rvalid_has_request_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instmem_rvalid_i |-> (outstanding_q != '0));

  // Slot reservation means a kept response never meets a full buffer without a pop.
  no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    buf_push |-> (!buf_full || buf_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit with an in-order latency memory and a stream-level model.
module tb_fetch_unit;
  import core_pkg::*;

  localparam int Max = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        hold_i;
  logic        instmem_ready_i;
  logic        instmem_valid_o;
  logic [31:0] instmem_addr_o;
  logic [31:0] instmem_rdata_i;
  logic        instmem_rvalid_i;
  logic        inst_valid_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_data_o;
  logic        inst_ready_i;

  fetch_unit dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .hold_i           (hold_i),
    .instmem_ready_i  (instmem_ready_i),
    .instmem_valid_o  (instmem_valid_o),
    .instmem_addr_o   (instmem_addr_o),
    .instmem_rdata_i  (instmem_rdata_i),
    .instmem_rvalid_i (instmem_rvalid_i),
    .inst_valid_o     (inst_valid_o),
    .inst_pc_o        (inst_pc_o),
    .inst_data_o      (inst_data_o),
    .inst_ready_i     (inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t mem_q[$];
  int   cycle_cnt = 0;
  int   mem_lat = 1;
  int   ready_pct = 100;

  // Stream-level model: next address to fetch, next pc the core must see, requests in flight.
  logic [31:0] model_pc, exp_pc;
  int          model_out;

  // Per-cycle observations and expectations.
  logic        s_pop, s_issue, s_valid, s_rvalid, s_redir, s_over;
  logic [31:0] s_pop_pc, s_pop_data, s_addr, s_redir_pc;
  logic [31:0] e_pop_pc, e_pop_data, e_addr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Sample just before the edge, advance one clock, update model and memory.
  task automatic tick();
    #3;
    s_valid    = instmem_valid_o;
    s_addr     = instmem_addr_o;
    s_issue    = instmem_valid_o && instmem_ready_i;
    s_redir    = redirect_valid_i;
    s_redir_pc = redirect_pc_i;
    e_addr     = redirect_valid_i ? redirect_pc_i : model_pc;
    s_over     = instmem_valid_o && (hold_i || model_out >= Max);
    s_pop      = inst_valid_o && inst_ready_i && !redirect_valid_i;
    s_pop_pc   = inst_pc_o;
    s_pop_data = inst_data_o;
    e_pop_pc   = exp_pc;
    e_pop_data = word_of(exp_pc);
    s_rvalid   = instmem_rvalid_i;
    if (s_pop) $display("[TB] cyc=%0d pop pc=%h inst=%h", cycle_cnt, s_pop_pc, s_pop_data);
    @(posedge clk_i);
    cycle_cnt++;
    if (s_issue) begin
      mem_q.push_back('{addr: s_addr, due: cycle_cnt + mem_lat - 1});
      model_pc = e_addr + 32'd4;
    end else if (s_redir) begin
      model_pc = s_redir_pc;
    end
    if (s_redir)    exp_pc = s_redir_pc;
    else if (s_pop) exp_pc = exp_pc + 32'd4;
    model_out = model_out + (s_issue ? 1 : 0) - (s_rvalid ? 1 : 0);
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cycle_cnt) begin
      instmem_rvalid_i = 1'b1;
      instmem_rdata_i  = word_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      instmem_rvalid_i = 1'b0;
      instmem_rdata_i  = $urandom;
    end
    instmem_ready_i = (int'($urandom_range(99)) < ready_pct);
  endtask

  task automatic model_clear();
    mem_q.delete();
    model_out        = 0;
    model_pc         = 32'h0;
    exp_pc           = 32'h0;
    instmem_rvalid_i = 1'b0;
    instmem_rdata_i  = 32'h0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0; hold_i = 1'b0;
    inst_ready_i = 1'b1; instmem_ready_i = 1'b1; mem_lat = 1; ready_pct = 100;
    model_clear();
    repeat (3) @(posedge clk_i);
    #4;
    tests_run++;
    if (instmem_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b expected 0", instmem_valid_o); end
    tests_run++;
    if (inst_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid_o); end
    tests_run++;
    if ({inst_pc_o, inst_data_o} !== 64'h0) begin tests_failed++; $display("FAIL reset_inst_out: got %h/%h expected 0/0", inst_pc_o, inst_data_o); end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    #1;
    tests_run++;
    if (instmem_addr_o !== 32'h0 || instmem_valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL reset_first_req: got valid=%b addr=%h expected 1/00000000", instmem_valid_o, instmem_addr_o);
    end
    #(-0);
  endtask

  task automatic test_stream();
    int pops = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_issue) begin
        tests_run++;
        if (s_addr !== e_addr) begin tests_failed++; $display("FAIL stream_addr: got %h expected %h", s_addr, e_addr); end
      end
      if (s_pop) begin
        tests_run++;
        if (s_pop_pc !== e_pop_pc || s_pop_data !== e_pop_data) begin
          tests_failed++; $display("FAIL stream_pop: got %h/%h expected %h/%h", s_pop_pc, s_pop_data, e_pop_pc, e_pop_data);
        end
        if (i >= 4) pops++;
      end
    end
    tests_run++;
    if (pops != 26) begin tests_failed++; $display("FAIL stream_rate: got %0d pops expected 26", pops); end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    inst_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_issue) begin
        tests_run++;
        if (s_addr !== e_addr) begin tests_failed++; $display("FAIL bp_addr: got %h expected %h", s_addr, e_addr); end
      end
    end
    tests_run++;
    if (s_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_req_stops: got valid=%b expected 0", s_valid); end
    tests_run++;
    if (model_out != 0 || inst_valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL bp_full: got outstanding=%0d inst_valid=%b expected 0/1", model_out, inst_valid_o);
    end
    inst_ready_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (s_issue) begin
        tests_run++;
        if (s_addr !== e_addr) begin tests_failed++; $display("FAIL bp_resume_addr: got %h expected %h", s_addr, e_addr); end
      end
      if (s_pop) begin
        pops++;
        tests_run++;
        if (s_pop_pc !== e_pop_pc || s_pop_data !== e_pop_data) begin
          tests_failed++; $display("FAIL bp_resume_pop: got %h/%h expected %h/%h", s_pop_pc, s_pop_data, e_pop_pc, e_pop_data);
        end
      end
    end
    tests_run++;
    if (pops < 10) begin tests_failed++; $display("FAIL bp_drain: got %0d pops expected >= 10", pops); end
  endtask

  task automatic test_latency_redirect();
    bit over_seen = 1'b0;
    bit got_issue = 1'b0, got_pop = 1'b0;
    int guard = 0;
    mem_lat = 3;
    while (model_out < Max && guard < 20) begin
      tick();
      guard++;
      if (s_over) over_seen = 1'b1;
    end
    tests_run++;
    if (model_out != Max) begin tests_failed++; $display("FAIL lat_fill: got outstanding=%0d expected %0d", model_out, Max); end
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    redirect_valid_i = 1'b0;
    tests_run++;
    if (s_addr !== 32'h100) begin tests_failed++; $display("FAIL lat_redir_addr: got %h expected 00000100", s_addr); end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_over) over_seen = 1'b1;
      if (s_issue) begin
        if (!got_issue) begin
          got_issue = 1'b1;
          tests_run++;
          if (s_addr !== 32'h100) begin tests_failed++; $display("FAIL lat_first_issue: got %h expected 00000100", s_addr); end
        end
        tests_run++;
        if (s_addr !== e_addr) begin tests_failed++; $display("FAIL lat_addr: got %h expected %h", s_addr, e_addr); end
      end
      if (s_pop) begin
        if (!got_pop) begin
          got_pop = 1'b1;
          tests_run++;
          if (s_pop_pc !== 32'h100) begin tests_failed++; $display("FAIL lat_first_pop: got %h expected 00000100", s_pop_pc); end
        end
        tests_run++;
        if (s_pop_pc !== e_pop_pc || s_pop_data !== e_pop_data) begin
          tests_failed++; $display("FAIL lat_pop: got %h/%h expected %h/%h", s_pop_pc, s_pop_data, e_pop_pc, e_pop_data);
        end
      end
    end
    tests_run++;
    if (over_seen || !got_pop) begin tests_failed++; $display("FAIL lat_credit: got over=%b delivered=%b expected 0/1", over_seen, got_pop); end
    mem_lat = 1;
  endtask

  task automatic test_redirect_collision();
    int guard = 0;
    bit got_pop = 1'b0;
    while (!(instmem_rvalid_i && instmem_valid_o) && guard < 20) begin
      tick();
      guard++;
    end
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    redirect_valid_i = 1'b0;
    tests_run++;
    if (!(s_rvalid && s_valid && s_addr === 32'h200)) begin
      tests_failed++; $display("FAIL coll_issue: got rvalid=%b valid=%b addr=%h expected 1/1/00000200", s_rvalid, s_valid, s_addr);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_pop) begin
        if (!got_pop) begin
          got_pop = 1'b1;
          tests_run++;
          if (s_pop_pc !== 32'h200) begin tests_failed++; $display("FAIL coll_first_pop: got %h expected 00000200", s_pop_pc); end
        end
        tests_run++;
        if (s_pop_pc !== e_pop_pc || s_pop_data !== e_pop_data) begin
          tests_failed++; $display("FAIL coll_pop: got %h/%h expected %h/%h", s_pop_pc, s_pop_data, e_pop_pc, e_pop_data);
        end
      end
    end
    tests_run++;
    if (!got_pop) begin tests_failed++; $display("FAIL coll_delivery: got no pop expected one"); end
  endtask

  task automatic test_hold();
    int pops = 0;
    hold_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (s_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_no_req: got valid=%b expected 0", s_valid); end
      if (s_pop) begin
        pops++;
        tests_run++;
        if (s_pop_pc !== e_pop_pc) begin tests_failed++; $display("FAIL hold_pop: got %h expected %h", s_pop_pc, e_pop_pc); end
      end
    end
    tests_run++;
    if (pops < 1) begin tests_failed++; $display("FAIL hold_drain: got %0d pops expected >= 1", pops); end
    hold_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (s_issue) begin
        tests_run++;
        if (s_addr !== e_addr) begin tests_failed++; $display("FAIL hold_resume_addr: got %h expected %h", s_addr, e_addr); end
      end
      if (s_pop) begin
        tests_run++;
        if (s_pop_pc !== e_pop_pc || s_pop_data !== e_pop_data) begin
          tests_failed++; $display("FAIL hold_resume_pop: got %h/%h expected %h/%h", s_pop_pc, s_pop_data, e_pop_pc, e_pop_data);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit got_pop = 1'b0;
    repeat (4) tick();
    #2 rst_ni = 1'b0;
    model_clear();
    #1;
    tests_run++;
    if ({instmem_valid_o, inst_valid_o} !== 2'b00 || {inst_pc_o, inst_data_o} !== 64'h0) begin
      tests_failed++; $display("FAIL midreset_async: got req=%b inst=%b pc=%h data=%h expected all 0", instmem_valid_o, inst_valid_o, inst_pc_o, inst_data_o);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    tests_run++;
    if (instmem_addr_o !== 32'h0) begin tests_failed++; $display("FAIL midreset_pc: got %h expected 00000000", instmem_addr_o); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_pop) begin
        if (!got_pop) begin
          got_pop = 1'b1;
          tests_run++;
          if (s_pop_pc !== 32'h0) begin tests_failed++; $display("FAIL midreset_first_pop: got %h expected 00000000", s_pop_pc); end
        end
        tests_run++;
        if (s_pop_pc !== e_pop_pc || s_pop_data !== e_pop_data) begin
          tests_failed++; $display("FAIL midreset_pop: got %h/%h expected %h/%h", s_pop_pc, s_pop_data, e_pop_pc, e_pop_data);
        end
      end
    end
  endtask

  task automatic test_random();
    int pops = 0;
    ready_pct = 70;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) mem_lat = int'($urandom_range(1, 4));
      inst_ready_i     = ($urandom_range(99) < 60);
      hold_i           = ($urandom_range(99) < 10);
      redirect_valid_i = ($urandom_range(99) < 5);
      redirect_pc_i    = $urandom & 32'hFFFF_FFFC;
      tick();
      tests_run++;
      if (s_over) begin tests_failed++; $display("FAIL rand_issue_rule: got valid=1 with hold=%b outstanding=%0d", hold_i, model_out); end
      if (s_issue) begin
        tests_run++;
        if (s_addr !== e_addr) begin tests_failed++; $display("FAIL rand_addr: got %h expected %h", s_addr, e_addr); end
      end
      if (s_pop) begin
        pops++;
        tests_run++;
        if (s_pop_pc !== e_pop_pc || s_pop_data !== e_pop_data) begin
          tests_failed++; $display("FAIL rand_pop: got %h/%h expected %h/%h", s_pop_pc, s_pop_data, e_pop_pc, e_pop_data);
        end
      end
    end
    redirect_valid_i = 1'b0; hold_i = 1'b0; ready_pct = 100; inst_ready_i = 1'b1;
    tests_run++;
    if (pops < 50) begin tests_failed++; $display("FAIL rand_progress: got %0d pops expected >= 50", pops); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_latency_redirect();
    test_redirect_collision();
    test_hold();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
